// File: rtl/accum_zone_ctrl_pkg.sv
//----------------------------------------------------------------------
// Package : accum_zone_ctrl_pkg
// Shared types and lane-wise wrap-around add for the accumulator zone.
// Rev     : 1.0
//----------------------------------------------------------------------
`default_nettype none

package accum_zone_ctrl_pkg;

  localparam int unsigned C_DEF_BUS_WIDTH  = 256;
  localparam int unsigned C_DEF_LANE_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WB = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    RD = 1'b0,
    WR = 1'b1
  } prio_e;

  // Each lane wraps independently; carries never cross a lane boundary.
  function automatic logic [C_DEF_BUS_WIDTH-1:0] lane_add(
    input logic [C_DEF_BUS_WIDTH-1:0] a,
    input logic [C_DEF_BUS_WIDTH-1:0] b
  );
    logic [C_DEF_BUS_WIDTH-1:0] s;
    s = '0;
    for (int unsigned l = 0; l < C_DEF_BUS_WIDTH / C_DEF_LANE_WIDTH; l++) begin
      s[l*C_DEF_LANE_WIDTH +: C_DEF_LANE_WIDTH] =
        a[l*C_DEF_LANE_WIDTH +: C_DEF_LANE_WIDTH] + b[l*C_DEF_LANE_WIDTH +: C_DEF_LANE_WIDTH];
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/accum_zone_ctrl_lane_adder.sv
//----------------------------------------------------------------------
// Module : accum_lane_adder
// Combinational lane-wise modulo adder (no carry between lanes).
// Rev    : 1.0
//----------------------------------------------------------------------
`default_nettype none

module accum_lane_adder #(
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned LANE_WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  localparam int unsigned NUM_LANES = WIDTH / LANE_WIDTH;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign o_sum[l*LANE_WIDTH +: LANE_WIDTH] =
      i_a[l*LANE_WIDTH +: LANE_WIDTH] + i_b[l*LANE_WIDTH +: LANE_WIDTH];
  end

endmodule

`default_nettype wire

// File: rtl/accum_zone_ctrl.sv
//----------------------------------------------------------------------
// Module : accum_zone_ctrl
// Zone responder: arbitrates write/accumulate vs read onto SRAM banks.
// Rev    : 1.0
//----------------------------------------------------------------------
`default_nettype none

module accum_zone_ctrl
  import accum_zone_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LANE_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic                            accum_en,
  input  logic [NUM_BANKS-1:0]            wr_mask,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  input  logic                            rd_valid,
  output logic                            rd_ready,
  input  logic [NUM_BANKS-1:0]            rd_mask,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic                            rvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_BANKS-1:0]            bank_ce,
  output logic [NUM_BANKS-1:0]            bank_we,
  output logic [ADDR_WIDTH-1:0]           bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata
);

  localparam int unsigned BUS_WIDTH = NUM_BANKS * DATA_WIDTH;

  state_e                  state_q, state_d;
  prio_e                   prio_q, prio_d;
  logic [NUM_BANKS-1:0]    mask_q, mask_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BUS_WIDTH-1:0]    wdata_q, wdata_d;
  logic                    rvalid_q, rvalid_d;
  logic [NUM_BANKS-1:0]    rd_mask_q, rd_mask_d;

  logic [BUS_WIDTH-1:0]    acc_sum;
  logic                    conflict;
  logic                    grant_wr;
  logic                    grant_rd;

  accum_lane_adder #(
    .WIDTH      (BUS_WIDTH),
    .LANE_WIDTH (LANE_WIDTH)
  ) u_lane_adder (
    .i_a   (bank_rdata),
    .i_b   (wdata_q),
    .o_sum (acc_sum)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      prio_q    <= RD;
      mask_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rd_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rvalid_q  <= rvalid_d;
      rd_mask_q <= rd_mask_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rvalid_d   = 1'b0;
    rd_mask_d  = rd_mask_q;
    wr_ready   = 1'b0;
    rd_ready   = 1'b0;
    bank_ce    = '0;
    bank_we    = '0;
    bank_addr  = wr_addr;
    bank_wdata = wdata;
    conflict   = wr_valid && rd_valid;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;

    case (state_q)
      IDLE: begin
        // Readies are gated by reset so nothing is granted while rstn is low.
        if (rstn) begin
          grant_rd = rd_valid && (!wr_valid || (prio_q == RD));
          grant_wr = wr_valid && !grant_rd;
          if (conflict) begin
            prio_d = (prio_q == RD) ? WR : RD;
          end

          if (grant_wr) begin
            wr_ready  = 1'b1;
            bank_ce   = wr_mask;
            bank_addr = wr_addr;
            if (accum_en) begin
              mask_d  = wr_mask;
              addr_d  = wr_addr;
              wdata_d = wdata;
              state_d = RMW_WB;
            end else begin
              bank_we    = wr_mask;
              bank_wdata = wdata;
            end
          end

          if (grant_rd) begin
            rd_ready  = 1'b1;
            bank_ce   = rd_mask;
            bank_addr = rd_addr;
            rvalid_d  = 1'b1;
            rd_mask_d = rd_mask;
          end
        end
      end

      RMW_WB: begin
        bank_ce    = mask_q;
        bank_we    = mask_q;
        bank_addr  = addr_q;
        bank_wdata = acc_sum;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rvalid = rvalid_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_rdata
    assign rdata[b*DATA_WIDTH +: DATA_WIDTH] =
      rd_mask_q[b] ? bank_rdata[b*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

endmodule

`default_nettype wire
